histogram_control: RTL and testbench
====================================

# histogram_control

Sequencing controller for the histogram datapath. On `start` it walks the input image one 128-bit word pair (32 pixels) at a time. For each pair it issues the input-memory read and load strobes, then runs 32 scratch read-modify-write bin updates. It raises `done` when the whole image is binned. It is the only driver of the datapath's control strobes, and it sits between the top-level host handshake and the datapath.

## Interface
- `NUM_WORD_PAIRS`, 128: input word pairs per image (64x64 8-bit pixels); legal 1..65535.
- `MEM_READ_LATENCY`, 1: cycles from a registered read address to valid read data, for input and scratch memories; legal 1..7.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin one histogram pass; sampled in IDLE only.
- `all_pixel_written` in 1: datapath flag, high once 32 bin writes are done since the last input address set.
- `set_read_address_input_mem` out 1: one-cycle strobe; the datapath advances or sets the input word-pair address.
- `read_data_ready_input_mem` out 1: one-cycle strobe; the datapath captures the input word pair and the bin/offset registers.
- `set_read_address_scratch_mem` out 1: one-cycle strobe; the datapath registers the current pixel's bin address.
- `read_data_ready_scratch_mem` out 1: one-cycle strobe; the datapath captures the scratch bin word.
- `set_write_address_scratch_mem` out 1: one-cycle strobe; the datapath registers the incremented word and write address.
- `shift_scratch_memory_rw_address` out 1: one-cycle strobe; the datapath advances to the next pixel.
- `busy` out 1: high from the accepted `start` until `done`.
- `done` out 1: one-cycle pulse at pass completion.
- `sequence_error` out 1: sticky flag; the datapath pixel flag disagrees with the internal pixel count.

## Operation
- States:
  - IDLE
  - SET_IN
  - WAIT_IN
  - IN_READY
  - SET_SCR
  - WAIT_SCR
  - SCR_READY
  - WRITE
  - SHIFT
  - DONE
- Each strobe is high exactly during its same-named state and is low in every other state.
  - SET_IN drives `set_read_address_input_mem`.
  - IN_READY drives `read_data_ready_input_mem`.
  - SET_SCR drives `set_read_address_scratch_mem`.
  - SCR_READY drives `read_data_ready_scratch_mem`.
  - WRITE drives `set_write_address_scratch_mem`.
  - SHIFT drives `shift_scratch_memory_rw_address`.
- State transitions:
  - IDLE to SET_IN when `start` is high. This clears `sequence_error`, pair_count and pixel_count.
  - SET_IN to WAIT_IN.
  - WAIT_IN stays for MEM_READ_LATENCY cycles (wait counter), then goes to IN_READY.
  - IN_READY to SET_SCR.
  - SET_SCR to WAIT_SCR.
  - WAIT_SCR stays for MEM_READ_LATENCY cycles, then goes to SCR_READY.
  - SCR_READY to WRITE.
  - WRITE to SHIFT; pixel_count increments (6-bit).
  - SHIFT branches on pixel_count:
    - pixel_count < 32: go to SET_SCR.
    - pixel_count == 32 and pair_count == NUM_WORD_PAIRS-1: go to DONE.
    - pixel_count == 32 otherwise: pair_count increments (16-bit), pixel_count clears, go to SET_IN.
  - DONE to IDLE.
- The controller never skips a strobe and never reorders strobes.
- A scratch write lands no later than the edge ending SHIFT, so the next pixel's SET_SCR read sees the updated bin. No same-bin forwarding is needed.
- Consistency check, evaluated in SHIFT:
  - Set `sequence_error` if `all_pixel_written` != (pixel_count == 32).
  - The error does not alter sequencing.
  - The flag holds until the next accepted `start` or reset.
- The datapath write enable stays asserted after the final write, rewriting an identical word. This is accepted and requires no controller action.

## Timing
- Reset values:
  - state IDLE
  - all strobes 0
  - `busy` 0
  - `done` 0
  - `sequence_error` 0
  - counters 0
- Reset assertion mid-pass aborts immediately. The next pass requires a datapath reset, because the datapath address pointers are not rewound by the controller.
- Let L = MEM_READ_LATENCY.
  - Per pixel: 4+L cycles.
  - Per word pair: P = 2+L+32*(4+L) cycles.
- Cycle 1 is the first SET_IN, the cycle after the edge that samples `start`.
  - `done` is high in cycle NUM_WORD_PAIRS*P+1.
  - `busy` is high in cycles 1..NUM_WORD_PAIRS*P+1.
- `start` high while `busy` is ignored. `start` high during DONE is ignored. `start` held high in IDLE begins a new pass on the cycle after DONE.

## Test plan
- Reset: assert `reset_n`=0 asynchronously mid-cycle -> all outputs 0 immediately; state IDLE after release.
- Single pair: NUM_WORD_PAIRS=1, L=1, `all_pixel_written` modelled correctly -> exactly 1 SET_IN, 32 of each scratch strobe, `done` in cycle 164, `sequence_error`=0.
- Full image: defaults with the real datapath and a memory model -> `done` in cycle 20865; scratch bin sums total 4096; bins match a reference histogram.
- Latency: L=2, NUM_WORD_PAIRS=2 -> P=196; `done` in cycle 393; every READY strobe lags its SET strobe by exactly 3 cycles.
- Mismatch: force `all_pixel_written`=1 in the SHIFT after pixel 5 -> `sequence_error` rises the next cycle and stays set; the pass still completes on schedule; the next `start` clears the flag.
- Start/reset races: pulse `start` in cycle 50 -> no effect. Drive `reset_n` low at cycle 100 -> strobes drop, `busy`=0. New `start` after reset -> fresh pass from cycle 1.

Source files
------------

// File: rtl/histogram_control_if.sv
// Host/datapath handshake bundle for the histogram controller.
// The controller side uses the slave modport; the host/datapath side uses master.
interface histogram_control_if;
    logic start;
    logic all_pixel_written;
    logic set_read_address_input_mem;
    logic read_data_ready_input_mem;
    logic set_read_address_scratch_mem;
    logic read_data_ready_scratch_mem;
    logic set_write_address_scratch_mem;
    logic shift_scratch_memory_rw_address;
    logic busy;
    logic done;
    logic sequence_error;

    modport slave (
        input  start,
        input  all_pixel_written,
        output set_read_address_input_mem,
        output read_data_ready_input_mem,
        output set_read_address_scratch_mem,
        output read_data_ready_scratch_mem,
        output set_write_address_scratch_mem,
        output shift_scratch_memory_rw_address,
        output busy,
        output done,
        output sequence_error
    );

    modport master (
        output start,
        output all_pixel_written,
        input  set_read_address_input_mem,
        input  read_data_ready_input_mem,
        input  set_read_address_scratch_mem,
        input  read_data_ready_scratch_mem,
        input  set_write_address_scratch_mem,
        input  shift_scratch_memory_rw_address,
        input  busy,
        input  done,
        input  sequence_error
    );
endinterface

// File: rtl/histogram_control.sv
// Sequencer for the histogram datapath: walks word pairs, then 32 pixel RMW updates each.
// Latency: (2+L+32*(4+L)) cycles per word pair, done one cycle after the last SHIFT.
// No backpressure: strobes are fixed-schedule; start is ignored unless idle.
module histogram_control #(
    parameter int unsigned NUM_WORD_PAIRS   = 128,
    parameter int unsigned MEM_READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    histogram_control_if.slave bus
);

    localparam logic [15:0] LAST_PAIR = 16'(NUM_WORD_PAIRS - 1);
    localparam logic [2:0]  LAST_WAIT = 3'(MEM_READ_LATENCY - 1);
    localparam logic [5:0]  PIXELS    = 6'd32;

    typedef enum logic [3:0] {
        IDLE,
        SET_IN,
        WAIT_IN,
        IN_READY,
        SET_SCR,
        WAIT_SCR,
        SCR_READY,
        WRITE,
        SHIFT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [5:0]  pixel_count_q, pixel_count_d;
    logic [15:0] pair_count_q, pair_count_d;
    logic        seq_err_q, seq_err_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wait_cnt_q    <= 3'd0;
            pixel_count_q <= 6'd0;
            pair_count_q  <= 16'd0;
            seq_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            pixel_count_q <= pixel_count_d;
            pair_count_q  <= pair_count_d;
            seq_err_q     <= seq_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        pixel_count_d = pixel_count_q;
        pair_count_d  = pair_count_q;
        seq_err_d     = seq_err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d       = SET_IN;
                    seq_err_d     = 1'b0;
                    pair_count_d  = 16'd0;
                    pixel_count_d = 6'd0;
                end
            end
            SET_IN: begin
                state_d    = WAIT_IN;
                wait_cnt_d = 3'd0;
            end
            WAIT_IN: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    state_d    = IN_READY;
                    wait_cnt_d = 3'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            IN_READY: state_d = SET_SCR;
            SET_SCR: begin
                state_d    = WAIT_SCR;
                wait_cnt_d = 3'd0;
            end
            WAIT_SCR: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    state_d    = SCR_READY;
                    wait_cnt_d = 3'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            SCR_READY: state_d = WRITE;
            WRITE: begin
                state_d       = SHIFT;
                pixel_count_d = pixel_count_q + 6'd1;
            end
            SHIFT: begin
                // Datapath flag must agree with our own pixel count; mismatch is only reported.
                if (bus.all_pixel_written != (pixel_count_q == PIXELS)) begin
                    seq_err_d = 1'b1;
                end
                if (pixel_count_q < PIXELS) begin
                    state_d = SET_SCR;
                end else if (pair_count_q == LAST_PAIR) begin
                    state_d = DONE;
                end else begin
                    state_d       = SET_IN;
                    pair_count_d  = pair_count_q + 16'd1;
                    pixel_count_d = 6'd0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset clears them at once.
    assign bus.set_read_address_input_mem      = (state_q == SET_IN);
    assign bus.read_data_ready_input_mem       = (state_q == IN_READY);
    assign bus.set_read_address_scratch_mem    = (state_q == SET_SCR);
    assign bus.read_data_ready_scratch_mem     = (state_q == SCR_READY);
    assign bus.set_write_address_scratch_mem   = (state_q == WRITE);
    assign bus.shift_scratch_memory_rw_address = (state_q == SHIFT);
    assign bus.busy                            = (state_q != IDLE);
    assign bus.done                            = (state_q == DONE);
    assign bus.sequence_error                  = seq_err_q;

endmodule

// File: tb/tb_histogram_control.sv
// Bench for histogram_control: three parameterisations driven by a table of passes,
// each checked cycle by cycle against a reference strobe schedule queue.
module tb_histogram_control;

    localparam logic [8:0] M_SETIN  = 9'h001;
    localparam logic [8:0] M_INRDY  = 9'h002;
    localparam logic [8:0] M_SETSCR = 9'h004;
    localparam logic [8:0] M_SCRRDY = 9'h008;
    localparam logic [8:0] M_WR     = 9'h010;
    localparam logic [8:0] M_SHIFT  = 9'h020;
    localparam logic [8:0] M_BUSY   = 9'h040;
    localparam logic [8:0] M_DONE   = 9'h080;

    typedef struct {
        int inst;
        int n;
        int l;
        int fpx;
        bit poke;
        int exp_done;
        bit exp_err;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start_v [3];
    logic       apw     [3];
    logic [8:0] obs     [3];
    int         fpx_v   [3];
    int         cnt     [3];
    int         pairs   [3];
    logic [8:0] exp_q   [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clock = ~clock;

    histogram_control_if if0();
    histogram_control_if if1();
    histogram_control_if if2();

    histogram_control #(.NUM_WORD_PAIRS(1), .MEM_READ_LATENCY(1)) u0 (
        .clock(clock), .reset_n(reset_n), .bus(if0));
    histogram_control #(.NUM_WORD_PAIRS(2), .MEM_READ_LATENCY(2)) u1 (
        .clock(clock), .reset_n(reset_n), .bus(if1));
    histogram_control u2 (
        .clock(clock), .reset_n(reset_n), .bus(if2));

    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if2.start = start_v[2];
    assign if0.all_pixel_written = apw[0];
    assign if1.all_pixel_written = apw[1];
    assign if2.all_pixel_written = apw[2];

    assign obs[0] = {if0.sequence_error, if0.done, if0.busy, if0.shift_scratch_memory_rw_address,
                     if0.set_write_address_scratch_mem, if0.read_data_ready_scratch_mem,
                     if0.set_read_address_scratch_mem, if0.read_data_ready_input_mem,
                     if0.set_read_address_input_mem};
    assign obs[1] = {if1.sequence_error, if1.done, if1.busy, if1.shift_scratch_memory_rw_address,
                     if1.set_write_address_scratch_mem, if1.read_data_ready_scratch_mem,
                     if1.set_read_address_scratch_mem, if1.read_data_ready_input_mem,
                     if1.set_read_address_input_mem};
    assign obs[2] = {if2.sequence_error, if2.done, if2.busy, if2.shift_scratch_memory_rw_address,
                     if2.set_write_address_scratch_mem, if2.read_data_ready_scratch_mem,
                     if2.set_read_address_scratch_mem, if2.read_data_ready_input_mem,
                     if2.set_read_address_input_mem};

    // Datapath model: bin writes since the last input address set, plus an optional bad flag.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i]   <= 0;
                pairs[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (obs[i][0]) begin
                    cnt[i]   <= 0;
                    pairs[i] <= pairs[i] + 1;
                end else if (obs[i][4]) begin
                    cnt[i] <= cnt[i] + 1;
                end
                if (obs[i][7]) pairs[i] <= 0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            apw[i] = (cnt[i] == 32) ||
                     (fpx_v[i] != 0 && obs[i][5] && cnt[i] == fpx_v[i] && pairs[i] == 1);
        end
    end

    task automatic check(input string name, input int cyc, input logic [8:0] act,
                         input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b required %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Reference schedule for one pass, ending with the IDLE cycle after DONE.
    task automatic build(input int n, input int l, input int fpx);
        logic e;
        e = 1'b0;
        exp_q.delete();
        for (int pr = 0; pr < n; pr++) begin
            exp_q.push_back({e, 8'h00} | M_SETIN | M_BUSY);
            for (int w = 0; w < l; w++) exp_q.push_back({e, 8'h00} | M_BUSY);
            exp_q.push_back({e, 8'h00} | M_INRDY | M_BUSY);
            for (int px = 0; px < 32; px++) begin
                exp_q.push_back({e, 8'h00} | M_SETSCR | M_BUSY);
                for (int w = 0; w < l; w++) exp_q.push_back({e, 8'h00} | M_BUSY);
                exp_q.push_back({e, 8'h00} | M_SCRRDY | M_BUSY);
                exp_q.push_back({e, 8'h00} | M_WR | M_BUSY);
                exp_q.push_back({e, 8'h00} | M_SHIFT | M_BUSY);
                if (pr == 0 && px + 1 == fpx) e = 1'b1;
            end
        end
        exp_q.push_back({e, 8'h00} | M_DONE | M_BUSY);
        exp_q.push_back({e, 8'h00});
    endtask

    task automatic run_pass(input vec_t v, input string name);
        int       cyc, done_cyc, n_setin, n_wr, last_set_in, last_set_scr, lag_bad;
        logic [8:0] e;
        build(v.n, v.l, v.fpx);
        fpx_v[v.inst] = v.fpx;
        cyc = 0; done_cyc = 0; n_setin = 0; n_wr = 0;
        last_set_in = 0; last_set_scr = 0; lag_bad = 0;
        @(negedge clock);
        start_v[v.inst] = 1'b1;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            cyc++;
            start_v[v.inst] = v.poke && (cyc == 50 || cyc == v.exp_done);
            e = exp_q.pop_front();
            check(name, cyc, obs[v.inst], e);
            if (obs[v.inst][0]) begin n_setin++; last_set_in = cyc; end
            if (obs[v.inst][2]) last_set_scr = cyc;
            if (obs[v.inst][1] && cyc - last_set_in != v.l + 1) lag_bad++;
            if (obs[v.inst][3] && cyc - last_set_scr != v.l + 1) lag_bad++;
            if (obs[v.inst][4]) n_wr++;
            if (obs[v.inst][7] && done_cyc == 0) done_cyc = cyc;
        end
        start_v[v.inst] = 1'b0;
        fpx_v[v.inst] = 0;
        check_int({name, "_done_cycle"}, done_cyc, v.exp_done);
        check_int({name, "_set_in_count"}, n_setin, v.n);
        check_int({name, "_write_count"}, n_wr, 32 * v.n);
        check_int({name, "_ready_lag_errors"}, lag_bad, 0);
        check_int({name, "_final_error_flag"}, int'(obs[v.inst][8]), int'(v.exp_err));
    endtask

    vec_t tbl [4];

    initial begin
        int hold_done;
        tbl[0] = '{inst: 0, n: 1,   l: 1, fpx: 5, poke: 1'b1, exp_done: 164,   exp_err: 1'b1};
        tbl[1] = '{inst: 0, n: 1,   l: 1, fpx: 0, poke: 1'b0, exp_done: 164,   exp_err: 1'b0};
        tbl[2] = '{inst: 1, n: 2,   l: 2, fpx: 0, poke: 1'b1, exp_done: 393,   exp_err: 1'b0};
        tbl[3] = '{inst: 2, n: 128, l: 1, fpx: 0, poke: 1'b0, exp_done: 20865, exp_err: 1'b0};

        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            fpx_v[i]   = 0;
        end
        #1;
        for (int i = 0; i < 3; i++) check("reset_state", 0, obs[i], 9'h000);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 3; i++) check("idle_after_release", 0, obs[i], 9'h000);

        for (int t = 0; t < 4; t++) run_pass(tbl[t], $sformatf("pass%0d", t));

        // start held high through DONE: one IDLE cycle, then a new pass.
        @(negedge clock);
        start_v[0] = 1'b1;
        hold_done = 0;
        for (int c = 0; c < 400 && hold_done == 0; c++) begin
            @(negedge clock);
            if (obs[0][7]) hold_done = 1;
        end
        check_int("hold_done_seen", hold_done, 1);
        @(negedge clock);
        check("hold_idle", 0, obs[0], 9'h000);
        @(negedge clock);
        check("hold_restart", 1, obs[0], M_SETIN | M_BUSY);
        start_v[0] = 1'b0;

        // Abort the restarted pass at cycle 100 with an asynchronous mid-cycle reset.
        repeat (99) @(negedge clock);
        check_int("pre_reset_busy", int'(obs[0][6]), 1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check("async_reset", 100, obs[i], 9'h000);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_after_abort", 0, obs[0], 9'h000);

        run_pass(tbl[1], "fresh_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
